eight_bit_div: RTL and testbench

Sequential unsigned divider and the inverse companion of the 8-bit multiplier.
- Takes a 2*WIDTH-bit dividend, such as a multiplier product, and a WIDTH-bit divisor.
- Returns a WIDTH-bit quotient and a WIDTH-bit remainder.
- Uses restoring shift-subtract, one quotient bit per clock.
- Valid/ready handshakes on both sides; used in the datapath wherever a product is rescaled.

---
 rtl/eight_bit_div_pkg.sv | 22 ++
 rtl/eight_bit_sub.sv | 19 +
 rtl/eight_bit_div.sv | 199 +++++++++++++++++++
 tb/tb_eight_bit_div.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eight_bit_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package eight_bit_div_pkg;

    // Controller states: waiting for operands, iterating, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default divisor/quotient/remainder width; dividend is twice this.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Iteration counter width for the default configuration.
    localparam int unsigned DEFAULT_CNT_WIDTH = $clog2(DEFAULT_WIDTH + 1);

    // Counter width needed to count 0..w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/eight_bit_sub.sv
// (WIDTH+1)-bit subtractor. A clear borrow means a_i >= b_i, so the borrow
// also serves as the trial-subtraction compare of the divider.
module eight_bit_sub
    import eight_bit_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   diff_o,
    output logic             borrow_o
);

    // One extra bit on both operands captures the borrow out of the MSB.
    always_comb begin
        {borrow_o, diff_o} = {1'b0, a_i} - {2'b00, b_i};
    end

endmodule

// File: rtl/eight_bit_div.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock, valid/ready on both sides.
// Divide-by-zero and quotient overflow are resolved at accept time.
module eight_bit_div
    import eight_bit_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int unsigned         CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     rpart_q, rpart_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic               oval_q, oval_d;

    logic [WIDTH-1:0]   div_hi;
    logic [WIDTH-1:0]   div_lo;
    logic               is_zero;
    logic               is_ovf;
    logic               last_iter;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     sub_diff;
    logic               sub_borrow;
    logic               q_bit;
    logic [WIDTH:0]     rpart_next;
    logic [WIDTH-1:0]   shreg_next;

    assign div_hi    = dividend[2*WIDTH-1:WIDTH];
    assign div_lo    = dividend[WIDTH-1:0];
    assign is_zero   = (divisor == '0);
    // High half >= divisor means the quotient needs more than WIDTH bits.
    assign is_ovf    = (div_hi >= divisor);
    assign last_iter = (cnt_q == LAST_ITER);

    // Shift the partial remainder left and pull in the next dividend bit.
    // The partial remainder is always below the divisor, so its MSB is zero
    // and the truncating cast drops nothing.
    assign trial = (WIDTH+1)'({rpart_q, shreg_q[WIDTH-1]});

    eight_bit_sub #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a_i      (trial),
        .b_i      (dvsr_q),
        .diff_o   (sub_diff),
        .borrow_o (sub_borrow)
    );

    assign q_bit      = ~sub_borrow;
    assign rpart_next = sub_borrow ? trial : sub_diff;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    assign shreg_next = {shreg_q[WIDTH-2:0], q_bit};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: errors skip RUN, hand-off returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (is_zero || is_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: ready only in IDLE, everything else straight from flops.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = oval_q;
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
        overflow    = ovf_q;
    end

    // Datapath next-state: operand capture, iteration and result load.
    always_comb begin
        rpart_d = rpart_q;
        shreg_d = shreg_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        oval_d  = oval_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvsr_d = divisor;
                    if (is_zero) begin
                        dbz_d  = 1'b1;
                        ovf_d  = 1'b0;
                        quot_d = '1;
                        rem_d  = div_lo;
                        oval_d = 1'b1;
                    end else if (is_ovf) begin
                        dbz_d  = 1'b0;
                        ovf_d  = 1'b1;
                        quot_d = '1;
                        rem_d  = '0;
                        oval_d = 1'b1;
                    end else begin
                        rpart_d = {1'b0, div_hi};
                        shreg_d = div_lo;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                rpart_d = rpart_next;
                shreg_d = shreg_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    quot_d = shreg_next;
                    rem_d  = WIDTH'(rpart_next);
                    oval_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    oval_d = 1'b0;
                end
            end
            default: begin
                oval_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset clears every result and flag immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpart_q <= '0;
            shreg_q <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            oval_q  <= 1'b0;
        end else begin
            rpart_q <= rpart_d;
            shreg_q <= shreg_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            oval_q  <= oval_d;
        end
    end

endmodule

// File: tb/tb_eight_bit_div.sv
// Self-checking bench for eight_bit_div: directed and randomized operations
// against an arithmetic reference model.
module tb_eight_bit_div;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eight_bit_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Reference: plain integer division; quotient must fit in 8 bits.
    // lat = clock edges after the accept edge until out_valid is seen.
    function automatic void model(input logic [15:0] dd, input logic [7:0] dv,
                                  output logic [17:0] res, output int lat);
        int unsigned q;
        if (dv == 8'd0) begin
            res = {8'hFF, dd[7:0], 1'b1, 1'b0};
            lat = 0;
        end else begin
            q = int'(dd) / int'(dv);
            if (q > 255) begin
                res = {8'hFF, 8'h00, 1'b0, 1'b1};
                lat = 0;
            end else begin
                res = {8'(q), 8'(int'(dd) % int'(dv)), 1'b0, 1'b0};
                lat = W;
            end
        end
    endfunction

    // Drives one operation (caller is between edges, DUT idle) and returns
    // what the DUT presents once out_valid appears. With noise set, in_valid
    // stays high with junk operands while the DUT is busy.
    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv, input bit noise,
                          output logic [17:0] res, output int lat,
                          output logic ir_acc, output int acc_cyc);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        ir_acc   = in_ready;
        in_valid = noise;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
        end
        in_valid = 1'b0;
        res = {quotient, remainder, div_by_zero, overflow};
    endtask

    // One edge with out_ready as set by the caller; report handshake state.
    task automatic step(output logic ov, output logic ir, output logic [17:0] res);
        @(posedge clk); #1;
        ov  = out_valid;
        ir  = in_ready;
        res = {quotient, remainder, div_by_zero, overflow};
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #12;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 19'd0}) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h",
                     {in_ready, out_valid, quotient, remainder, div_by_zero, overflow}, {1'b1, 19'd0});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed;
        logic [15:0] dds [3] = '{16'h03E8, 16'hFE01, 16'h0C35};
        logic [7:0]  dvs [3] = '{8'h07, 8'hFF, 8'h19};
        logic [17:0] exp [3] = '{{8'h8E, 8'h06, 2'b00}, {8'hFF, 8'h00, 2'b00}, {8'h7D, 8'h00, 2'b00}};
        logic [17:0] res;
        logic ir, ov, ir2;
        int lat, ac;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(dds[i], dvs[i], 1'b0, res, lat, ir, ac);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL directed_%0d_result got=%h exp=%h", i, res, exp[i]);
            end
            checks++;
            if (lat != W) begin
                errors++;
                $display("FAIL directed_%0d_latency got=%0d exp=%0d", i, lat, W);
            end
            checks++;
            if (ir !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d_busy_ready got=%b exp=0", i, ir);
            end
            step(ov, ir2, res);
            checks++;
            if ({ov, ir2} !== 2'b01 || res !== exp[i]) begin
                errors++;
                $display("FAIL directed_%0d_handoff got ov=%b ir=%b res=%h exp ov=0 ir=1 res=%h",
                         i, ov, ir2, res, exp[i]);
            end
        end
    endtask

    task automatic test_errors_and_edges;
        logic [15:0] dds [4] = '{16'h1234, 16'h0800, 16'h07FF, 16'h0000};
        logic [7:0]  dvs [4] = '{8'h00, 8'h08, 8'h08, 8'h01};
        logic [17:0] exp [4] = '{{8'hFF, 8'h34, 2'b10}, {8'hFF, 8'h00, 2'b01},
                                 {8'hFF, 8'h07, 2'b00}, {8'h00, 8'h00, 2'b00}};
        int          elat [4] = '{0, 0, W, W};
        logic [17:0] res;
        logic ir, ov, ir2;
        int lat, ac;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(dds[i], dvs[i], 1'b0, res, lat, ir, ac);
            checks++;
            if (res !== exp[i] || lat != elat[i]) begin
                errors++;
                $display("FAIL edge_%0d got res=%h lat=%0d exp res=%h lat=%0d",
                         i, res, lat, exp[i], elat[i]);
            end
            step(ov, ir2, res);
            checks++;
            if ({ov, ir2} !== 2'b01) begin
                errors++;
                $display("FAIL edge_%0d_handoff got ov=%b ir=%b exp ov=0 ir=1", i, ov, ir2);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [17:0] res, held, exp;
        logic ir, ov, ir2;
        int lat, elat, ac;
        out_ready = 1'b0;
        run_op(16'h03E8, 8'h07, 1'b1, held, lat, ir, ac);
        checks++;
        if (held !== {8'h8E, 8'h06, 2'b00} || lat != W) begin
            errors++;
            $display("FAIL bp_result got res=%h lat=%0d exp res=%h lat=%0d",
                     held, lat, {8'h8E, 8'h06, 2'b00}, W);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            step(ov, ir2, res);
            checks++;
            if ({ov, ir2} !== 2'b10 || res !== held) begin
                errors++;
                $display("FAIL bp_hold_%0d got ov=%b ir=%b res=%h exp ov=1 ir=0 res=%h",
                         i, ov, ir2, res, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(ov, ir2, res);
        checks++;
        if ({ov, ir2} !== 2'b01 || res !== held) begin
            errors++;
            $display("FAIL bp_release got ov=%b ir=%b res=%h exp ov=0 ir=1 res=%h",
                     ov, ir2, res, held);
        end
        model(16'hABCD, 8'hC1, exp, elat);
        run_op(16'hABCD, 8'hC1, 1'b0, res, lat, ir, ac);
        checks++;
        if (res !== exp || lat != elat) begin
            errors++;
            $display("FAIL bp_next got res=%h lat=%0d exp res=%h lat=%0d", res, lat, exp, elat);
        end
        step(ov, ir2, res);
    endtask

    task automatic test_reset_mid_run;
        logic [17:0] res;
        logic ir, ov, ir2;
        int lat, ac;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 16'h03E8;
        divisor   = 8'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 19'd0}) begin
            errors++;
            $display("FAIL midrun_reset got=%h exp=%h",
                     {in_ready, out_valid, quotient, remainder, div_by_zero, overflow}, {1'b1, 19'd0});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(ov, ir2, res);
        checks++;
        if ({ov, ir2} !== 2'b01) begin
            errors++;
            $display("FAIL midrun_release got ov=%b ir=%b exp ov=0 ir=1", ov, ir2);
        end
        run_op(16'h0064, 8'h0A, 1'b0, res, lat, ir, ac);
        checks++;
        if (res !== {8'h0A, 8'h00, 2'b00} || lat != W) begin
            errors++;
            $display("FAIL midrun_fresh got res=%h lat=%0d exp res=%h lat=%0d",
                     res, lat, {8'h0A, 8'h00, 2'b00}, W);
        end
        step(ov, ir2, res);
        // Reset while a result is waiting in DONE drops it.
        out_ready = 1'b0;
        run_op(16'h1234, 8'h00, 1'b0, res, lat, ir, ac);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 19'd0}) begin
            errors++;
            $display("FAIL done_reset got=%h exp=%h",
                     {in_ready, out_valid, quotient, remainder, div_by_zero, overflow}, {1'b1, 19'd0});
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_random;
        logic [17:0] res, exp, res2;
        logic [15:0] dd;
        logic [7:0]  dv;
        logic ir, ov, ir2;
        int lat, elat, ac, kind, stall;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                dv = 8'h00;
                dd = 16'($urandom);
            end else if (kind < 7) begin
                dv = 8'($urandom_range(1, 255));
                dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom)};
            end else begin
                dv = 8'($urandom);
                dd = 16'($urandom);
            end
            stall     = $urandom_range(0, 3);
            out_ready = (stall == 0);
            model(dd, dv, exp, elat);
            run_op(dd, dv, 1'($urandom_range(0, 1)), res, lat, ir, ac);
            checks++;
            if (res !== exp || lat != elat) begin
                errors++;
                $display("FAIL random_%0d %h/%h got res=%h lat=%0d exp res=%h lat=%0d",
                         n, dd, dv, res, lat, exp, elat);
            end
            for (int s = 0; s < stall; s++) begin
                step(ov, ir2, res2);
                checks++;
                if ({ov, ir2} !== 2'b10 || res2 !== exp) begin
                    errors++;
                    $display("FAIL random_%0d_stall got ov=%b ir=%b res=%h exp ov=1 ir=0 res=%h",
                             n, ov, ir2, res2, exp);
                end
            end
            out_ready = 1'b1;
            step(ov, ir2, res2);
            checks++;
            if ({ov, ir2} !== 2'b01) begin
                errors++;
                $display("FAIL random_%0d_handoff got ov=%b ir=%b exp ov=0 ir=1", n, ov, ir2);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] res, exp;
        logic [15:0] dd;
        logic [7:0]  dv;
        logic ir, ov, ir2;
        int lat, elat, ac, prev_ac;
        out_ready = 1'b1;
        prev_ac   = -1;
        for (int n = 0; n < 6; n++) begin
            dv = 8'($urandom_range(1, 255));
            dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom)};
            model(dd, dv, exp, elat);
            run_op(dd, dv, 1'b0, res, lat, ir, ac);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL b2b_%0d got=%h exp=%h", n, res, exp);
            end
            if (prev_ac >= 0) begin
                checks++;
                if (ac - prev_ac != W + 2) begin
                    errors++;
                    $display("FAIL b2b_%0d_spacing got=%0d exp=%0d", n, ac - prev_ac, W + 2);
                end
            end
            prev_ac = ac;
            step(ov, ir2, res);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors_and_edges();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
